// File: rtl/tribus_receiver.sv
// Receive side of an inverting tri-state bus: polarity restore, turnaround gap, output FIFO.
// Optional even-parity check over {data, parity} is enabled by defining TRIBUS_PARITY_CHK_EN.
module tribus_receiver #(
    parameter int W        = 8,
    parameter int DEPTH    = 4,
    parameter int TURN_CYC = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] ZN_BUS,
    input  logic         ZP,
    input  logic         EN_ANY,
    output logic         RDY,
    output logic [W-1:0] DOUT,
    output logic         OVLD,
    input  logic         ORDY,
    output logic [W-1:0] KEEP,
    output logic [7:0]   DROP,
    output logic         PERR
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t           state_q;
    logic [3:0]       turn_q;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [W-1:0]     keep_q,   keep_d;
    logic [7:0]       drop_q,   drop_d;

    logic [W-1:0]     word;
    logic             bad_par;
    logic             push;
    logic             drop;
    logic             pop;

    assign word = ~ZN_BUS;

`ifdef TRIBUS_PARITY_CHK_EN
    logic perr_q;

    assign bad_par = ^{word, ~ZP};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perr_q <= 1'b0;
        end else if (EN_ANY && bad_par) begin
            perr_q <= 1'b1;
        end
    end

    assign PERR = perr_q;
`else
    logic unused_zp;

    assign unused_zp = ZP;
    assign bad_par   = 1'b0;
    assign PERR      = 1'b0;
`endif

    // RDY is qualified by RST directly so drivers see it fall without waiting for a clock.
    assign RDY  = !RST && (state_q != TURN) && (count_q < CNT_W'(DEPTH));
    assign OVLD = (count_q != '0);
    assign DOUT = mem_q[rd_ptr_q];
    assign KEEP = keep_q;
    assign DROP = drop_q;

    assign push = EN_ANY &&  RDY && !bad_par;
    assign drop = EN_ANY && !RDY && !bad_par;
    assign pop  = OVLD && ORDY;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            turn_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (EN_ANY) state_q <= BURST;
                end
                BURST: begin
                    if (!EN_ANY) begin
                        state_q <= TURN;
                        turn_q  <= 4'(TURN_CYC);
                    end
                end
                TURN: begin
                    turn_q <= turn_q - 4'd1;
                    if (turn_q == 4'd1) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        keep_d   = keep_q;
        drop_d   = drop_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            keep_d   = word;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            keep_q   <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            keep_q   <= keep_d;
            drop_q   <= drop_d;
        end
    end

    // NOTE: storage is not reset; clearing the pointers and count empties the FIFO.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

endmodule

// File: tb/tb_tribus_receiver.sv
// Scoreboard bench for tribus_receiver: directed bus cycles push expected words, a monitor pops on handshake.
module tb_tribus_receiver;

`ifdef TRIBUS_PARITY_CHK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] zn_bus = 8'h00;
    logic       zp = 1'b0;
    logic       en_any = 1'b0;
    logic       ordy = 1'b0;
    logic       rdy, ovld, perr;
    logic [7:0] dout, keep, drop;

    logic       en2 = 1'b0;
    logic [7:0] zn2 = 8'h00;
    logic       zp2 = 1'b0;
    logic       ordy2 = 1'b1;
    logic       rdy2, ovld2, perr2;
    logic [7:0] dout2, keep2, drop2;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    tribus_receiver #(.W(8), .DEPTH(4), .TURN_CYC(1)) dut (
        .CLK(clk), .RST(rst), .ZN_BUS(zn_bus), .ZP(zp), .EN_ANY(en_any),
        .RDY(rdy), .DOUT(dout), .OVLD(ovld), .ORDY(ordy),
        .KEEP(keep), .DROP(drop), .PERR(perr)
    );

    tribus_receiver #(.W(8), .DEPTH(4), .TURN_CYC(2)) dut2 (
        .CLK(clk), .RST(rst), .ZN_BUS(zn2), .ZP(zp2), .EN_ANY(en2),
        .RDY(rdy2), .DOUT(dout2), .OVLD(ovld2), .ORDY(ordy2),
        .KEEP(keep2), .DROP(drop2), .PERR(perr2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Parity line value that makes {~zn, ~zp} even.
    function automatic logic gp(input logic [7:0] zn_val);
        return ~(^zn_val);
    endfunction

    // One bus cycle on dut: drive at posedge+1, check RDY at negedge, return at next posedge+1.
    task automatic cyc(input logic en, input logic [7:0] zn_val, input logic zp_val,
                       input logic ordy_val, input logic exp_rdy, input logic acc);
        en_any = en;
        zn_bus = zn_val;
        zp     = zp_val;
        ordy   = ordy_val;
        if (acc) exp_q.push_back(~zn_val);
        @(negedge clk);
        check("rdy", rdy, exp_rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc2(input logic en, input logic [7:0] zn_val, input logic exp_rdy);
        en2 = en;
        zn2 = zn_val;
        zp2 = gp(zn_val);
        @(negedge clk);
        check("rdy2", rdy2, exp_rdy);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && ovld && ordy) begin
            if (exp_q.size() == 0) check("sb_pop_empty", ovld, 1'b0);
            else                   check("sb_dout", dout, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        #1;
        check("rdy_in_reset", rdy, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rdy", rdy, 1'b1);
        check("rst_ovld", ovld, 1'b0);
        check("rst_keep", keep, 8'h00);
        check("rst_drop", drop, 8'h00);
        check("rst_perr", perr, 1'b0);
        @(posedge clk);
        #1;

        // Turnaround of 2: words offered right after the burst ends are dropped.
        cyc2(1'b1, 8'hFF, 1'b1);
        check("t2_ovld", ovld2, 1'b1);
        check("t2_dout", dout2, 8'h00);
        cyc2(1'b0, 8'hFF, 1'b1);
        cyc2(1'b1, 8'hAA, 1'b0);
        cyc2(1'b1, 8'hBB, 1'b0);
        cyc2(1'b1, 8'h3C, 1'b1);
        cyc2(1'b0, 8'h00, 1'b1);
        check("t2_drop", drop2, 8'd2);
        check("t2_keep", keep2, 8'hC3);
        check("t2_perr", perr2, 1'b0);

        // Single-cycle burst, one-cycle latency, one TURN cycle.
        cyc(1'b1, 8'h5A, gp(8'h5A), 1'b0, 1'b1, 1'b1);
        check("one_ovld", ovld, 1'b1);
        check("one_dout", dout, 8'hA5);
        check("one_keep", keep, 8'hA5);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        check("one_empty", ovld, 1'b0);

        // Six-word burst into a 4-deep FIFO: last two dropped.
        for (int i = 0; i < 6; i++) begin
            logic [7:0] z;
            z = 8'hFE - 8'(i);
            cyc(1'b1, z, gp(z), 1'b0, (i < 4), (i < 4));
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("burst_drop", drop, 8'd2);
        check("burst_keep", keep, 8'h04);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("burst_empty", ovld, 1'b0);

        // Full FIFO with pop and offer in the same cycle: word dropped, retried next cycle.
        cyc(1'b1, 8'hEF, gp(8'hEF), 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 8'hDF, gp(8'hDF), 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 8'hCF, gp(8'hCF), 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 8'hBF, gp(8'hBF), 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 8'hAF, gp(8'hAF), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'hAF, gp(8'hAF), 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("full_drop", drop, 8'd3);
        check("full_keep", keep, 8'h50);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("full_empty", ovld, 1'b0);

        // Bad parity word followed by a good one.
        cyc(1'b1, 8'hFE, 1'b1, 1'b0, 1'b1, !PAR_EN);
        check("par_perr", perr, PAR_EN);
        check("par_keep", keep, PAR_EN ? 8'h50 : 8'h01);
        cyc(1'b1, 8'hFE, gp(8'hFE), 1'b0, 1'b1, 1'b1);
        check("par_perr_hold", perr, PAR_EN);
        check("par_keep2", keep, 8'h01);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("par_empty", ovld, 1'b0);
        check("par_drop", drop, 8'd3);

        // Asynchronous reset in the middle of a burst.
        cyc(1'b1, 8'h0F, gp(8'h0F), 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 8'h1F, gp(8'h1F), 1'b0, 1'b1, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_rdy", rdy, 1'b0);
        check("arst_ovld", ovld, 1'b0);
        check("arst_keep", keep, 8'h00);
        check("arst_drop", drop, 8'h00);
        check("arst_perr", perr, 1'b0);
        exp_q.delete();
        en_any = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("arst_rdy_after", rdy, 1'b1);
        check("arst_ovld_after", ovld, 1'b0);
        check("sb_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tribus_receiver.md
Name: tribus_receiver

Overview:
- Receiving end of the shared tri-state data bus built from inverting tri-state drivers. Each driver places the inverted word on the bus while its EN is high.
- The block senses the bus, restores true polarity and enforces a turnaround gap between driver bursts.
- It buffers accepted words in a small FIFO for the downstream consumer, and keeps a bus-keeper copy of the last accepted word.

Parameters:
- W, 8, data width of the bus word.
- DEPTH, 4, FIFO depth in words; power of 2, minimum 2.
- TURN_CYC, 1, turnaround cycles (1..15) after a burst ends, during which RDY is held low.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- ZN_BUS  input  W  bus data as driven, in inverted polarity.
- ZP  input  1  bus parity line, inverted polarity.
- EN_ANY  input  1  wired-OR of all driver enables; high = bus driven this cycle.
- RDY  output  1  to drivers; high = word on bus is accepted at next CLK edge.
- DOUT  output  W  FIFO head word, true polarity.
- OVLD  output  1  DOUT valid.
- ORDY  input  1  consumer ready; pop when OVLD & ORDY.
- KEEP  output  W  last accepted word, true polarity.
- DROP  output  8  saturating count of words offered while RDY low.
- PERR  output  1  sticky parity error flag.

Behaviour:
- Reset: RST is asynchronous and active-high. Asserting it clears FIFO, state (->IDLE), KEEP=0, DROP=0, PERR=0, OVLD=0. RDY=0 while RST high. Any word in flight is discarded.
- States:
  - IDLE: EN_ANY=0. EN_ANY=1 -> BURST.
  - BURST: EN_ANY=1. EN_ANY=0 -> TURN, loading turn counter with TURN_CYC.
  - TURN: counter decrements each cycle; at 0 -> IDLE. EN_ANY is ignored for transitions here. Words offered during TURN are drops.
- RDY is combinational from registered values: RDY = !RST && state!=TURN && count<DEPTH.
- Accept: on a CLK edge with EN_ANY & RDY, word = ~ZN_BUS is pushed and KEEP <= word. Pushes happen in both IDLE (first word of a burst) and BURST. Latency bus->OVLD is 1 cycle.
- Drop: on a CLK edge with EN_ANY & !RDY, DROP increments and saturates at 255. Nothing is written and KEEP is unchanged.
- Pop: on a CLK edge with OVLD & ORDY the head advances. DOUT/OVLD come directly from FIFO registers, with no extra stage.
- Simultaneous push and pop, not full: both occur and count is unchanged.
- Full plus pop in the same cycle: RDY was already low, so the offered word is dropped. No same-cycle bypass.
- Empty plus pop: impossible, because OVLD=0.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Bursts longer than FIFO space: the excess words are drops, and the state stays BURST.

Optional Feature:
- Macro: TRIBUS_PARITY_CHK_EN.
- Defined:
  - Even parity is checked over {~ZN_BUS, ~ZP}.
  - A word with bad parity is not pushed and KEEP is not updated. PERR sets and holds until RST.
  - Bad words are not counted in DROP.
- Undefined: ZP is ignored, PERR is tied 0, and all accepted words are pushed.

Test Plan:
- Reset then idle -> RDY=1, OVLD=0, KEEP=0x00, DROP=0; assert RST mid-burst -> FIFO empties and RDY=0 immediately, without waiting for a clock edge.
- One-cycle EN_ANY with ZN_BUS=0x5A, ORDY=0 -> next cycle OVLD=1, DOUT=0xA5, KEEP=0xA5; RDY=0 for exactly 1 cycle (TURN), then 1.
- 6-cycle burst ZN_BUS=0xFE,0xFD,...,0xF9 with ORDY=0 -> FIFO holds 0x01..0x04, DROP=2, KEEP=0x04; then ORDY=1 drains 0x01,0x02,0x03,0x04 in order.
- Burst ends, new EN_ANY on the cycle right after, with TURN_CYC=2 -> 2 words dropped (DROP+=2); the word on the third cycle is accepted.
- FIFO full with ORDY=1 and EN_ANY=1 in the same cycle -> one pop, offered word dropped; next cycle RDY=1 and the word is accepted.
- With TRIBUS_PARITY_CHK_EN: ZN_BUS=0xFE, ZP=1 (bad parity) -> no push, PERR=1 and stays set; a following good word is pushed normally. Without the macro, the same stimulus pushes 0x01 and PERR=0.
